// File: rtl/char_glyph_reader_if.sv
// ---------------------------------------------------------------------------
// char_glyph_reader_if
// Bundles the request stream, the character-memory read port and the pixel
// stream of char_glyph_reader.
//   slave  modport : seen by the reader itself
//   master modport : seen by the surrounding logic (request source, memory
//                    array, scan-out consumer)
// Signals
//   req_valid/req_ready/req_char : glyph request handshake, 6-bit code
//   mem_x/mem_y/mem_rd/mem_data  : shared cell address, read strobe, and the
//                                  NUM_CHARS-wide read bus (one bit per glyph)
//   pix_valid/pix_ready          : pixel stream handshake
//   pix_bit/pix_col/pix_row      : cell value and its coordinates
//   pix_last                     : final cell of the glyph
//   bad_char                     : pulse after accepting an out-of-range code
//   invert                       : present only with CHAR_GLYPH_READER_INVERT_EN
// ---------------------------------------------------------------------------
interface char_glyph_reader_if #(
    parameter int NUM_CHARS = 36
);
    logic                 req_valid;
    logic                 req_ready;
    logic [5:0]           req_char;
`ifdef CHAR_GLYPH_READER_INVERT_EN
    logic                 invert;
`endif
    logic [1:0]           mem_x;
    logic [2:0]           mem_y;
    logic                 mem_rd;
    logic [NUM_CHARS-1:0] mem_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_bit;
    logic [1:0]           pix_col;
    logic [2:0]           pix_row;
    logic                 pix_last;
    logic                 bad_char;

    modport slave (
`ifdef CHAR_GLYPH_READER_INVERT_EN
        input  invert,
`endif
        input  req_valid,
        input  req_char,
        input  mem_data,
        input  pix_ready,
        output req_ready,
        output mem_x,
        output mem_y,
        output mem_rd,
        output pix_valid,
        output pix_bit,
        output pix_col,
        output pix_row,
        output pix_last,
        output bad_char
    );

    modport master (
`ifdef CHAR_GLYPH_READER_INVERT_EN
        output invert,
`endif
        output req_valid,
        output req_char,
        output mem_data,
        output pix_ready,
        input  req_ready,
        input  mem_x,
        input  mem_y,
        input  mem_rd,
        input  pix_valid,
        input  pix_bit,
        input  pix_col,
        input  pix_row,
        input  pix_last,
        input  bad_char
    );
endinterface

// File: rtl/char_glyph_reader.sv
// ---------------------------------------------------------------------------
// char_glyph_reader
// Read-side sequencer for the 4x5 character memory array of the VGA text
// path. A request latches a character code; the reader then walks the
// glyph's cells row-major, presenting each cell address to the array,
// waiting MEM_LATENCY cycles, sampling bit [char] of the read bus and
// emitting it as one pixel on a valid/ready stream.
//
// Ports
//   i_clock : system clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : char_glyph_reader_if.slave (request, memory port, pixel stream)
//
// Build option
//   CHAR_GLYPH_READER_INVERT_EN : adds bus.invert, sampled with the request;
//   when set every emitted pixel is complemented (invalid codes give 1s).
//
// State table
//   state    | meaning
//   ST_IDLE  | ready for a request (req_ready=1)
//   ST_FETCH | cell address on mem_x/mem_y, mem_rd=1
//   ST_WAIT  | address held while the array produces data
//   ST_EMIT  | pixel presented, waiting for pix_ready
// ---------------------------------------------------------------------------
module char_glyph_reader #(
    parameter int NUM_CHARS   = 36,
    parameter int GLYPH_W     = 4,
    parameter int GLYPH_H     = 5,
    parameter int MEM_LATENCY = 1
) (
    input  logic               i_clock,
    input  logic               i_rst_n,
    char_glyph_reader_if.slave bus
);

    localparam int         IDX_W      = $clog2(NUM_CHARS);
    localparam logic [5:0] CHAR_LIMIT = 6'(NUM_CHARS);
    localparam logic [1:0] X_LAST     = 2'(GLYPH_W - 1);
    localparam logic [2:0] Y_LAST     = 3'(GLYPH_H - 1);
    // Down-counter load: WAIT ends when the count reaches zero.
    localparam logic [1:0] WAIT_LOAD  = (MEM_LATENCY > 0) ? 2'(MEM_LATENCY - 1) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    state_t     r_state;
    logic [5:0] r_char;
    logic       r_bad;
    logic [1:0] r_x;
    logic [2:0] r_y;
    logic [1:0] r_wait_cnt;
    logic       r_req_ready;
    logic       r_mem_rd;
    logic       r_pix_valid;
    logic       r_pix_bit;
    logic [1:0] r_pix_col;
    logic [2:0] r_pix_row;
    logic       r_pix_last;
    logic       r_bad_char;
`ifdef CHAR_GLYPH_READER_INVERT_EN
    logic       r_inv;
`endif

    logic [IDX_W-1:0] w_idx;
    logic             w_cell;
    logic             w_pix_bit;
    logic             w_req_bad;
    logic             w_x_wrap;
    logic             w_cell_last;
    logic [1:0]       w_next_x;
    logic [2:0]       w_next_y;

    // An invalid code steers the select to bit 0 so the read bus is never
    // indexed past its width; the value is then masked to 0 anyway.
    assign w_idx     = r_bad ? '0 : r_char[IDX_W-1:0];
    assign w_cell    = r_bad ? 1'b0 : bus.mem_data[w_idx];
`ifdef CHAR_GLYPH_READER_INVERT_EN
    assign w_pix_bit = w_cell ^ r_inv;
`else
    assign w_pix_bit = w_cell;
`endif

    assign w_req_bad   = (bus.req_char >= CHAR_LIMIT);
    assign w_x_wrap    = (r_x == X_LAST);
    assign w_cell_last = w_x_wrap && (r_y == Y_LAST);
    assign w_next_x    = w_x_wrap ? 2'd0 : r_x + 2'd1;
    assign w_next_y    = w_x_wrap ? r_y + 3'd1 : r_y;

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_char      <= 6'd0;
            r_bad       <= 1'b0;
            r_x         <= 2'd0;
            r_y         <= 3'd0;
            r_wait_cnt  <= 2'd0;
            r_req_ready <= 1'b1;
            r_mem_rd    <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_bit   <= 1'b0;
            r_pix_col   <= 2'd0;
            r_pix_row   <= 3'd0;
            r_pix_last  <= 1'b0;
            r_bad_char  <= 1'b0;
`ifdef CHAR_GLYPH_READER_INVERT_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            r_bad_char <= 1'b0;
            r_mem_rd   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_char      <= bus.req_char;
                        r_bad       <= w_req_bad;
                        r_bad_char  <= w_req_bad;
`ifdef CHAR_GLYPH_READER_INVERT_EN
                        r_inv       <= bus.invert;
`endif
                        r_x         <= 2'd0;
                        r_y         <= 3'd0;
                        r_mem_rd    <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (MEM_LATENCY == 0) begin
                        // Zero-latency array: data already valid this cycle.
                        r_pix_bit   <= w_pix_bit;
                        r_pix_col   <= r_x;
                        r_pix_row   <= r_y;
                        r_pix_last  <= w_cell_last;
                        r_pix_valid <= 1'b1;
                        r_state     <= ST_EMIT;
                    end else begin
                        r_wait_cnt  <= WAIT_LOAD;
                        r_state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_pix_bit   <= w_pix_bit;
                        r_pix_col   <= r_x;
                        r_pix_row   <= r_y;
                        r_pix_last  <= w_cell_last;
                        r_pix_valid <= 1'b1;
                        r_state     <= ST_EMIT;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt - 2'd1;
                    end
                end

                ST_EMIT: begin
                    if (bus.pix_ready) begin
                        r_pix_valid <= 1'b0;
                        if (w_cell_last) begin
                            r_req_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_x         <= w_next_x;
                            r_y         <= w_next_y;
                            r_mem_rd    <= 1'b1;
                            r_state     <= ST_FETCH;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.mem_x     = r_x;
    assign bus.mem_y     = r_y;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_bit   = r_pix_bit;
    assign bus.pix_col   = r_pix_col;
    assign bus.pix_row   = r_pix_row;
    assign bus.pix_last  = r_pix_last;
    assign bus.bad_char  = r_bad_char;

endmodule
